// File: rtl/ss_rmw_store.sv
// ss_rmw_store: sequential read-modify-write store unit merging byte/half/word stores into memory words.
// Optional SS_MISALIGN_TRAP_EN adds a misalign output that traps unaligned half/word stores.
module ss_rmw_store #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        SSControl,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] B_out,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
`ifdef SS_MISALIGN_TRAP_EN
   output logic              misalign,
`endif
   output logic              done
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int CW = $clog2(RD_LAT) + 1;
   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q, rdata_q, lane, mask;
   logic [1:0] size_q;
   logic [CW-1:0] cnt;
   logic [OFF_W-1:0] k;
   logic [OFF_W+2:0] sh;
   logic accept, full, mis, last;
   assign accept = state == IDLE && start && SSControl != 2'b00;
   assign full = DATA_W == 32 && SSControl == 2'b01;
   assign last = cnt == CW'(RD_LAT - 1);
`ifdef SS_MISALIGN_TRAP_EN
   logic mis_q;
   assign mis = (SSControl == 2'b10 && Addr[0]) || (SSControl == 2'b01 && Addr[1:0] != 2'b00);
   assign misalign = state == DONE && mis_q;
`else
   assign mis = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = !accept ? IDLE : mis ? DONE : full ? WR : RD;
         RD:   state_nx = WAIT;
         WAIT: state_nx = last ? WR : WAIT;
         WR:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         addr_q <= '0;
         data_q <= '0;
         size_q <= '0;
         rdata_q <= '0;
         cnt <= '0;
`ifdef SS_MISALIGN_TRAP_EN
         mis_q <= 1'b0;
`endif
      end else begin
         if (accept) begin
            addr_q <= Addr;
            data_q <= B_out;
            size_q <= SSControl;
`ifdef SS_MISALIGN_TRAP_EN
            mis_q <= mis;
`endif
         end
         cnt <= state == WAIT ? cnt + 1'b1 : '0;
         if (state == WAIT && last) rdata_q <= mem_rdata;
      end
   // lane offset aligned down to the access size; word mask covers the whole word when DATA_W is 32
   assign k = addr_q[OFF_W-1:0] & ~(size_q == 2'b11 ? OFF_W'(0) : size_q == 2'b10 ? OFF_W'(1) : OFF_W'(3));
   assign sh = {k, 3'b000};
   assign lane = size_q == 2'b11 ? DATA_W'(32'hFF) : size_q == 2'b10 ? DATA_W'(32'hFFFF) : DATA_W'(32'hFFFF_FFFF);
   assign mask = lane << sh;
   assign mem_wdata = (rdata_q & ~mask) | ((data_q << sh) & mask);
   assign mem_addr = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign mem_rd = state == RD;
   assign mem_wr = state == WR;
   assign busy = state != IDLE;
   assign done = state == DONE;
endmodule

// File: doc/ss_rmw_store.md
# ss_rmw_store

Sequential read-modify-write store unit for the multicycle datapath; successor to the combinational store-size merge. On a `start` pulse it latches address, store data and size, reads the containing memory word when a partial store is needed, merges the byte or halfword into the lane selected by the low address bits, and writes the merged word back. It sits between the B register / ALU address path and the memory port, and `done` is handed to the control FSM.

## Interface
- `DATA_W`, 32: memory word width; multiple of 32 (32 or 64).
- `ADDR_W`, 32: byte address width.
- `RD_LAT`, 1: memory read latency in cycles, ≥1.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request strobe, sampled in IDLE only.
- `SSControl` in 2: store size; 01 word (32 b), 10 half, 11 byte, 00 none.
- `Addr` in ADDR_W: byte address of the store.
- `B_out` in DATA_W: store data; the operand is in the low bits.
- `mem_rdata` in DATA_W: memory read data.
- `mem_addr` out ADDR_W: word-aligned address (low OFF_W = log2(DATA_W/8) bits zero).
- `mem_rd` out 1: read strobe, one cycle.
- `mem_wr` out 1: write strobe, one cycle.
- `mem_wdata` out DATA_W: merged write data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: exists only with `SS_MISALIGN_TRAP_EN`; valid while `done`=1.

## Operation
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE with `start`=1 and `SSControl`≠00: latch `Addr`, `B_out` and `SSControl`. Go to WR if the store size equals `DATA_W` (word store with `DATA_W`=32); otherwise go to RD.
- `start` with `SSControl`=00, or `start` in any state other than IDLE: ignored. No latch, no `done`.
- RD: `mem_rd`=1 for one cycle, then WAIT.
- WAIT: a counter runs for `RD_LAT` cycles. `mem_rdata` is captured in the last WAIT cycle, then WR.
- WR: `mem_wr`=1 for one cycle with `mem_wdata` = merged word, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Merge is little-endian. Byte offset k = `Addr[OFF_W-1:0]`.
  - Byte store replaces bits [8k+7:8k] with `B_out[7:0]`.
  - Half store replaces [8k+15:8k] with `B_out[15:0]`.
  - Word store replaces [8k+31:8k] with `B_out[31:0]`.
  - All other bits come from the captured read word.
- Full-width word store: `mem_wdata` = `B_out` and no read is issued.
- `mem_addr` holds the aligned latched address from RD through WR.
- Without the macro, misaligned addresses are aligned down: k is forced to a multiple of the access size.
- Reset (any state, asynchronous): all outputs 0, state IDLE, latched registers 0. A store in flight is abandoned. If reset lands in the WR cycle, the write strobe is dropped.

## Timing
- Request accepted at the edge ending cycle 0.
- Partial store:
  - RD in cycle 1.
  - WAIT in cycles 2 .. 1+`RD_LAT`.
  - WR in cycle 2+`RD_LAT`.
  - `done` in cycle 3+`RD_LAT`.
  - Next `start` accepted in cycle 4+`RD_LAT`.
- Full-width store: WR in cycle 1, `done` in cycle 2.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- `busy` is 1 from cycle 1 through the `done` cycle inclusive.

## Configuration
- `SS_MISALIGN_TRAP_EN` defined:
  - Half store with k odd, or word store with k not a multiple of 4, goes IDLE→DONE directly.
  - No `mem_rd`, no `mem_wr`.
  - `done`=1 with `misalign`=1 in cycle 1. `misalign` is 0 otherwise.
- Not defined:
  - The `misalign` port and its logic are absent.
  - Misaligned addresses are aligned down as in Operation.

## Test plan
- Byte, `RD_LAT`=1: memory[0x100]=0xAABBCCDD, `Addr`=0x102, `B_out`=0x11223344, `SSControl`=11 -> `mem_rd` in cycle 1, `mem_wr` in cycle 3 with `mem_wdata`=0xAA44CCDD and `mem_addr`=0x100, `done` in cycle 4.
- Half: same memory word, `Addr`=0x102, `B_out`=0x00005566, `SSControl`=10 -> `mem_wdata`=0x5566CCDD. With `Addr`=0x100 -> 0xAABB5566.
- Word, `DATA_W`=32: `Addr`=0x200, `B_out`=0xDEADBEEF, `SSControl`=01 -> no `mem_rd`; `mem_wr` in cycle 1 with 0xDEADBEEF; `done` in cycle 2.
- Latency and protocol, `RD_LAT`=3, byte store: `mem_wr` in cycle 5, `done` in cycle 6. A second `start` pulsed in cycle 3 is ignored. `SSControl`=00 gives no `done`.
- Reset mid-operation: deassert `reset_n` during WAIT -> all outputs 0 immediately and no `mem_wr`. A new byte store after release completes normally.
- Macro on: half store to `Addr`=0x101 -> `done`=1 and `misalign`=1 in cycle 1, no memory strobes. Macro off: same stimulus writes lane 0 (result 0xAABB5566).
